// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg
// Shared constants, configuration record and helpers for the serial pattern detector.
// No ports; imported by mealy_seq_detector and seq_history.
package mealy_seq_pkg;

    // Widest configuration any instance can hold (MAX_LEN range is 2..16).
    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned LEN_W_MAX = 5;

    localparam logic [PAT_W_MAX-1:0] RST_PATTERN = 16'b101;
    localparam logic [LEN_W_MAX-1:0] RST_LEN     = 5'd3;
    localparam logic                 RST_OVERLAP = 1'b1;

    // Latched pattern configuration. Pattern is right-aligned; bits above len are ignored.
    typedef struct packed {
        logic [PAT_W_MAX-1:0] pat;
        logic [LEN_W_MAX-1:0] len;
        logic                 ovl;
    } cfg_t;

    // Lengths below 2 become 2; lengths above the instance maximum become the maximum.
    function automatic logic [LEN_W_MAX-1:0] clamp_len(input logic [LEN_W_MAX-1:0] len,
                                                       input logic [LEN_W_MAX-1:0] max_len);
        logic [LEN_W_MAX-1:0] r;
        r = len;
        if (len < 5'd2) begin
            r = 5'd2;
        end else if (len > max_len) begin
            r = max_len;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_history.sv
// seq_history
// Shift register of the most recent accepted bits plus a saturating count of valid bits.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_shift        : accept i_din this cycle (shift left, newest in bit 0)
//   i_din          : serial data bit
//   i_clr_fill     : with i_shift, restart the valid-bit count at 0
//   i_clr_all      : clear history and valid-bit count (overrides everything)
//   o_hist         : history bits, newest in bit 0
//   o_fill         : number of valid bits in o_hist, saturates at MAX_LEN-1
module seq_history #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_shift,
    input  logic               i_din,
    input  logic               i_clr_fill,
    input  logic               i_clr_all,
    output logic [MAX_LEN-2:0] o_hist,
    output logic [LEN_W-1:0]   o_fill
);
    import mealy_seq_pkg::*;

    localparam logic [LEN_W-1:0] FillMax = LEN_W'(MAX_LEN - 1);

    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_shifted;

    // Full-width concatenation keeps the slice legal even when MAX_LEN is 2.
    assign w_shifted = {r_hist, i_din};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr_all) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_shifted[MAX_LEN-2:0];
            if (i_clr_fill) begin
                r_fill <= '0;
            end else if (r_fill != FillMax) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

    assign o_hist = r_hist;
    assign o_fill = r_fill;

endmodule

// File: rtl/mealy_seq_detector.sv
// mealy_seq_detector
// Mealy detector comparing the most recent len accepted bits against a loadable pattern.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_ena, i_din        : bit-valid strobe and serial data bit
//   i_cfg_load          : latch i_cfg_*; clears history and counter, discards i_din
//   i_cfg_pattern       : pattern, right-aligned, bit len-1 arrives first
//   i_cfg_len           : pattern length (clamped to 2..MAX_LEN)
//   i_cfg_overlap       : 1 = overlapping detection
//   i_count_clr         : synchronous counter clear
//   o_match             : combinational match on the current bit
//   o_match_q           : o_match registered
//   o_count, o_count_sat: saturating match counter and its all-ones flag
module mealy_seq_detector #(
    parameter int unsigned         MAX_LEN     = 8,
    parameter int unsigned         CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(mealy_seq_pkg::RST_PATTERN),
    parameter int unsigned         RST_LEN     = 3,
    parameter logic                RST_OVERLAP = mealy_seq_pkg::RST_OVERLAP,
    localparam int unsigned        LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ena,
    input  logic               i_din,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic               i_count_clr,
    output logic               o_match,
    output logic               o_match_q,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_count_sat
);
    import mealy_seq_pkg::*;

    cfg_t               r_cfg;
    logic               r_match_q;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-2:0] w_hist;
    logic [LEN_W-1:0]   w_fill;
    logic               w_accept;
    logic               w_match;
    logic               w_filled;
    logic [PAT_W_MAX-1:0] w_win;
    logic [PAT_W_MAX-1:0] w_mask;

    assign w_accept = i_ena & ~i_cfg_load;

    seq_history #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_seq_history (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_shift    (w_accept),
        .i_din      (i_din),
        .i_clr_fill (w_match & ~r_cfg.ovl),
        .i_clr_all  (i_cfg_load),
        .o_hist     (w_hist),
        .o_fill     (w_fill)
    );

    // Compare at the package's full width; the mask hides bits at or above len.
    assign w_win = PAT_W_MAX'({w_hist, i_din});

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(PAT_W_MAX); i++) begin
            w_mask[i] = (LEN_W_MAX'(i) < r_cfg.len);
        end
    end

    // len is always >= 2 after clamping, so len-1 cannot underflow.
    assign w_filled = (LEN_W_MAX'(w_fill) >= (r_cfg.len - LEN_W_MAX'(1)));
    assign w_match  = w_accept & w_filled & (((w_win ^ r_cfg.pat) & w_mask) == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg.pat <= PAT_W_MAX'(RST_PATTERN);
            r_cfg.len <= LEN_W_MAX'(RST_LEN);
            r_cfg.ovl <= RST_OVERLAP;
        end else if (i_cfg_load) begin
            r_cfg.pat <= PAT_W_MAX'(i_cfg_pattern);
            r_cfg.len <= clamp_len(LEN_W_MAX'(i_cfg_len), LEN_W_MAX'(MAX_LEN));
            r_cfg.ovl <= i_cfg_overlap;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (i_cfg_load) begin
                r_count <= '0;
            end else if (i_count_clr) begin
                // A match coinciding with the clear is still counted.
                r_count <= CNT_W'(w_match);
            end else if (w_match && !(&r_count)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_match     = w_match;
    assign o_match_q   = r_match_q;
    assign o_count     = r_count;
    assign o_count_sat = &r_count;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// tb_mealy_seq_detector
// Table-driven, hand-written and random checks of mealy_seq_detector (MAX_LEN=8, CNT_W=2)
// against a queue-based reference model.
module tb_mealy_seq_detector;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               ena;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   count;
    logic               count_sat;

    mealy_seq_detector #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ena         (ena),
        .i_din         (din),
        .i_cfg_load    (cfg_load),
        .i_cfg_pattern (cfg_pattern),
        .i_cfg_len     (cfg_len),
        .i_cfg_overlap (cfg_overlap),
        .i_count_clr   (count_clr),
        .o_match       (match),
        .o_match_q     (match_q),
        .o_count       (count),
        .o_count_sat   (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits accepted since the last clear, oldest first.
    int             m_bits[$];
    logic [7:0]     m_pat;
    int             m_len;
    bit             m_ovl;
    int             m_count;
    bit             m_match_q;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat     = 8'b101;
        m_len     = 3;
        m_ovl     = 1'b1;
        m_count   = 0;
        m_match_q = 1'b0;
    endtask

    function automatic bit model_match(input bit e, input bit d, input bit ld);
        int n;
        int b;
        if (!e || ld) return 1'b0;
        n = m_bits.size();
        if (n + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            b = (k == m_len - 1) ? int'(d) : m_bits[n - (m_len - 1) + k];
            if (b != int'(m_pat[m_len - 1 - k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_clock(input bit e, input bit d, input bit ld, input bit clr);
        bit mt;
        int l;
        mt = model_match(e, d, ld);
        if (ld) begin
            l = int'(cfg_len);
            if (l < 2) l = 2;
            if (l > int'(MAX_LEN)) l = MAX_LEN;
            m_pat   = cfg_pattern;
            m_len   = l;
            m_ovl   = cfg_overlap;
            m_bits.delete();
            m_count = 0;
        end else begin
            if (e) begin
                m_bits.push_back(int'(d));
                if (m_bits.size() > 16) void'(m_bits.pop_front());
                if (mt && !m_ovl) m_bits.delete();
            end
            if (clr) m_count = mt ? 1 : 0;
            else if (mt && m_count < CNT_MAX) m_count++;
        end
        m_match_q = mt;
    endtask

    // One clock: drive at negedge, check o_match mid-low-phase, check registers after posedge.
    // exp_m >= 0 adds an explicit expectation for o_match on top of the model.
    task automatic step(input bit e, input bit d, input bit ld, input bit clr, input int exp_m);
        @(negedge clk);
        ena = e; din = d; cfg_load = ld; count_clr = clr;
        #2;
        check("match_vs_model", int'(match), int'(model_match(e, d, ld)));
        if (exp_m >= 0) check("match_explicit", int'(match), exp_m);
        @(posedge clk);
        model_clock(e, d, ld, clr);
        #1;
        check("match_q", int'(match_q), int'(m_match_q));
        check("count", int'(count), m_count);
        check("count_sat", int'(count_sat), int'(m_count == CNT_MAX));
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = o;
        step(1'b1, 1'b1, 1'b1, 1'b0, 0);
    endtask

    typedef struct {
        bit ena;
        bit din;
        bit exp_match;
        bit exp_match_q;
        int exp_count;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [15:0] a5a5;
        int l;

        rst_n = 1'b0; ena = 1'b0; din = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        #2;
        check("reset_match", int'(match), 0);
        check("reset_match_q", int'(match_q), 0);
        check("reset_count", int'(count), 0);
        check("reset_sat", int'(count_sat), 0);
        #10 rst_n = 1'b1;

        // Reset defaults, overlapping 101.
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
        foreach (vecs[i]) begin
            step(vecs[i].ena, vecs[i].din, 1'b0, 1'b0, int'(vecs[i].exp_match));
            check("tbl_match_q", int'(match_q), int'(vecs[i].exp_match_q));
            check("tbl_count", int'(count), vecs[i].exp_count);
        end

        // Non-overlapping 101.
        load(8'b101, 3, 1'b0);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
        check("novl_count", int'(count), 1);

        // 8-bit pattern A5 twice, overlapping.
        load(8'hA5, 8, 1'b1);
        a5a5 = 16'hA5A5;
        for (int i = 0; i < 16; i++) begin
            step(1, a5a5[15 - i], 0, 0, (i == 7 || i == 15) ? 1 : 0);
        end
        check("a5_count", int'(count), 2);

        // ena gaps with toggling din.
        load(8'b101, 3, 1'b1);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, i[0], 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, ~i[0], 0, 0, 0);
        step(1, 1, 0, 0, 1);
        check("gap_count", int'(count), 1);

        // Load mid-stream discards history and the load-cycle bit.
        step(1, 1, 0, 0, -1); step(1, 0, 0, 0, 0);
        load(8'b101, 3, 1'b1);
        step(1, 1, 0, 0, 0);

        // Length 0 is stored as 2: pattern 01 matches after two bits.
        load(8'b01, 0, 1'b1);
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 1);

        // Counter saturation and clear-with-match.
        load(8'b11, 2, 1'b1);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);
        check("sat_count", int'(count), 3);
        check("sat_flag", int'(count_sat), 1);
        step(1, 1, 0, 1, 1);
        check("clr_match_count", int'(count), 1);
        check("clr_match_sat", int'(count_sat), 0);

        // Asynchronous reset mid-sequence.
        load(8'b101, 3, 1'b1);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        @(negedge clk);
        ena = 1'b1; din = 1'b1;
        #2;
        check("pre_rst_match", int'(match), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_match", int'(match), 0);
        check("async_rst_match_q", int'(match_q), 0);
        check("async_rst_count", int'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 30) == 0) begin
                l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(2, 4));
                cfg_pattern = 8'($urandom);
                cfg_len     = LEN_W'(l);
                cfg_overlap = 1'($urandom);
                step(1'($urandom), 1'($urandom), 1'b1, 1'b0, 0);
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0,
                     $urandom_range(0, 40) == 0, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
